// File: rtl/fifo_modport.sv
// Single-clock byte FIFO with registered read data and occupancy/full/empty status.
// Optional sticky overflow/underflow flags when FIFO_ERR_FLAGS_EN is defined.
module fifo_modport #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [CNT_W-1:0]  fifo_counter
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_acc;
  logic              rd_acc;

  // Status comes only from the registered count, so no input reaches an output.
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      rdata_d  = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge wr_clk) begin
    if (rst && wr_acc) mem_q[wr_ptr_q] <= wdata;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge wr_clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en && full)  ovf_q <= 1'b1;
      if (rd_en && empty) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

  assign rdata        = rdata_q;
  assign fifo_counter = cnt_q;

endmodule

// File: tb/tb_fifo_modport.sv
// Directed and randomized bench for fifo_modport against a queue-based reference model.
// Build with FIFO_ERR_FLAGS_EN defined to also check the sticky error flags.
module tb_fifo_modport;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              wr_clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  fifo_counter;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_rdata;
  logic              exp_ovf;
  logic              exp_unf;

  fifo_modport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .fifo_counter (fifo_counter)
  );

  // Clock / reset block
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = CNT_W'(exp_q.size());
    tests_run++;
    assert (fifo_counter === exp_cnt) else begin
      tests_failed++;
      $error("FAIL %s count: observed %0d expected %0d", tag, fifo_counter, exp_cnt);
    end
    check_bit({tag, " empty"}, empty, exp_q.size() == 0);
    check_bit({tag, " full"}, full, exp_q.size() == DEPTH);
    check_vec({tag, " rdata"}, rdata, exp_rdata);
`ifdef FIFO_ERR_FLAGS_EN
    check_bit({tag, " overflow"}, overflow, exp_ovf);
    check_bit({tag, " underflow"}, underflow, exp_unf);
`endif
  endtask

  // Driver: apply one cycle of stimulus, advance the model, then check.
  task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] d,
                      input logic rd, input string tag);
    bit m_full, m_empty;
    @(negedge wr_clk);
    rst   = r;
    wr_en = w;
    wdata = d;
    rd_en = rd;
    @(posedge wr_clk);
    #1;
    if (!r) begin
      exp_q.delete();
      exp_rdata = '0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      m_full  = (exp_q.size() == DEPTH);
      m_empty = (exp_q.size() == 0);
      if (w && m_full)  exp_ovf = 1'b1;
      if (rd && m_empty) exp_unf = 1'b1;
      if (rd && !m_empty) exp_rdata = exp_q.pop_front();
      if (w && !m_full)  exp_q.push_back(d);
    end
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(1'b0, $urandom_range(0, 1), DATA_W'($urandom), $urandom_range(0, 1), tag);
  endtask

  initial begin
    int written;
    int iter;
    logic w, r;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    exp_rdata = '0; exp_ovf = 1'b0; exp_unf = 1'b0;

    do_reset(2, "reset0");

    for (int i = 0; i < 150; i++)
      step(1'b1, $urandom_range(0, 1), DATA_W'($urandom), $urandom_range(0, 1), "random");

    do_reset(2, "reset_after_traffic");

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DATA_W'(8'h10 + i), 1'b0, "fill");
    step(1'b1, 1'b1, 8'hFF, 1'b0, "fill_overflow");
    check_bit("full_after_9th", full, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, "drain");
      check_vec("drain_order", rdata, DATA_W'(8'h10 + i));
    end
    step(1'b1, 1'b0, '0, 1'b1, "drain_underflow");
    check_vec("rdata_hold_17", rdata, 8'h17);

    do_reset(1, "reset_sim");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b0, "sim3_load");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b1, "sim3_both");
    while (exp_q.size() < DEPTH) step(1'b1, 1'b1, DATA_W'($urandom), 1'b0, "simfull_load");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b1, "simfull_both");
    while (exp_q.size() > 0) step(1'b1, 1'b0, '0, 1'b1, "simempty_drain");
    step(1'b1, 1'b1, DATA_W'($urandom), 1'b1, "simempty_both");
    while (exp_q.size() > 0) step(1'b1, 1'b0, '0, 1'b1, "simempty_flush");

    // Wrap-around: 20 bytes, occupancy kept within 1..5 once started
    written = 0;
    iter = 0;
    while ((written < 20 || exp_q.size() > 0) && iter < 500) begin
      w = (written < 20) && (exp_q.size() < 5) && ($urandom_range(0, 1) == 1 || exp_q.size() == 0);
      r = (exp_q.size() > 1 || (written == 20 && exp_q.size() > 0)) && ($urandom_range(0, 1) == 1 || written == 20);
      if (w) written++;
      step(1'b1, w, DATA_W'($urandom), r, "wrap");
      iter++;
    end
    check_bit("wrap_done", iter < 500, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b0, "mid_load");
    step(1'b0, 1'b1, DATA_W'($urandom), 1'b1, "mid_reset");
    step(1'b1, 1'b1, 8'hA5, 1'b0, "mid_write");
    step(1'b1, 1'b0, '0, 1'b1, "mid_read");
    check_vec("mid_rdata_a5", rdata, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
